// File: rtl/dm_store_buffer.sv
// dm_store_buffer: word-store buffer between the MEM stage and the data memory.
// It accepts stores into a circular queue and drains them one per cycle in
// program order. Loads are forwarded from the youngest matching entry, and they
// take priority over drains on the shared memory address port.
// Optional macro STBUF_TRACE_EN prints drain commits and dropped stores.
module dm_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [31:0]      st_pc,
    output logic             st_ready,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic [31:0]      ld_data,
    output logic             ld_hit,
    output logic             dm_MemWrite,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_writeData,
    output logic [31:0]      dm_PC,
    input  logic [31:0]      dm_readData,
    output logic [PTR_W:0]   count,
    output logic             empty
);

    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WADR_W = 30;

    // Entry storage; contents are qualified by valid_q, so no reset is needed
    logic [WADR_W-1:0] addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [31:0]       pc_q   [DEPTH];

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              push;
    logic              drain;
    logic              ld_mem;
    logic              fwd_hit;
    logic [31:0]       fwd_data;

    // Store byte-offset bits never reach the buffer
    logic              unused_st_lsb;
    assign unused_st_lsb = ^st_addr[1:0];

    assign st_ready = (count_q < CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign push     = st_valid & st_ready;

    // Youngest-match search: walk oldest to youngest so the last match wins
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && valid_q[idx] &&
                (addr_q[idx] == ld_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    // Load result and memory-port arbitration; a missing load owns the port
    always_comb begin
        ld_hit       = 1'b0;
        ld_data      = '0;
        dm_MemWrite  = 1'b0;
        dm_addr      = '0;
        dm_writeData = '0;
        dm_PC        = '0;
        ld_mem       = ld_valid & ~fwd_hit;
        drain        = (count_q != '0) & ~ld_mem;
        if (ld_valid) begin
            ld_hit  = fwd_hit;
            ld_data = fwd_hit ? fwd_data : dm_readData;
        end
        if (drain) begin
            dm_MemWrite  = 1'b1;
            dm_addr      = {addr_q[rd_ptr_q], 2'b00};
            dm_writeData = data_q[rd_ptr_q];
            dm_PC        = pc_q[rd_ptr_q];
        end else if (ld_mem) begin
            dm_addr      = ld_addr;
        end
    end

    // Next-state for pointers, occupancy and valid bits
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (drain) begin
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end
        case ({push, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry payload capture on an accepted store
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= st_addr[31:2];
            data_q[wr_ptr_q] <= st_data;
            pc_q[wr_ptr_q]   <= st_pc;
        end
    end

`ifdef STBUF_TRACE_EN
    // Commit and drop trace at the clock edge
    always @(posedge clk) begin
        if (reset) begin
            if (drain)
                $display("@%h: *%h <= %h", dm_PC, dm_addr, dm_writeData);
            if (st_valid && !st_ready)
                $display("STBUF: drop @%h", st_pc);
        end
    end
`else
    // Trace disabled: no simulation output
`endif

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_dm_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             st_valid;
    logic [31:0]      st_addr, st_data, st_pc;
    logic             st_ready;
    logic             ld_valid;
    logic [31:0]      ld_addr, ld_data;
    logic             ld_hit;
    logic             dm_MemWrite;
    logic [31:0]      dm_addr, dm_writeData, dm_PC, dm_readData;
    logic [PTR_W:0]   count;
    logic             empty;

    int n_cmp = 0;
    int n_bad = 0;

    dm_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_hit(ld_hit),
        .dm_MemWrite(dm_MemWrite), .dm_addr(dm_addr), .dm_writeData(dm_writeData),
        .dm_PC(dm_PC), .dm_readData(dm_readData),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    ent_t q[$];   // oldest at index 0

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Youngest buffered store with the same word address
    function automatic void model_fwd(input logic [31:0] la, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == la[31:2]) begin
                h = 1'b1;
                d = q[i].d;
                break;
            end
        end
    endfunction

    // Compare process: expected outputs from model contents and current inputs
    always @(negedge clk) begin
        logic        h, ldm, dr;
        logic [31:0] fd, e_ld, e_addr, e_wd, e_pc;
        if (!reset) q.delete();
        model_fwd(ld_addr, h, fd);
        ldm    = ld_valid && !h;
        dr     = (q.size() > 0) && !ldm;
        e_ld   = !ld_valid ? 32'h0 : (h ? fd : dm_readData);
        e_addr = dr ? {q[0].a, 2'b00} : (ldm ? ld_addr : 32'h0);
        e_wd   = dr ? q[0].d : 32'h0;
        e_pc   = dr ? q[0].p : 32'h0;
        chk("m_st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_empty", 32'(empty), 32'(q.size() == 0));
        chk("m_ld_hit", 32'(ld_hit), 32'(ld_valid && h));
        chk("m_ld_data", ld_data, e_ld);
        chk("m_memwrite", 32'(dm_MemWrite), 32'(dr));
        chk("m_dm_addr", dm_addr, e_addr);
        chk("m_dm_wdata", dm_writeData, e_wd);
        chk("m_dm_pc", dm_PC, e_pc);
    end

    // Model state update at each active edge
    always @(posedge clk) begin
        logic        h, ldm, dr, ps;
        logic [31:0] fd;
        ent_t        e;
        if (reset) begin
            model_fwd(ld_addr, h, fd);
            ldm = ld_valid && !h;
            dr  = (q.size() > 0) && !ldm;
            ps  = st_valid && (q.size() < DEPTH);
            e.a = st_addr[31:2];
            e.d = st_data;
            e.p = st_pc;
            if (dr) void'(q.pop_front());
            if (ps) q.push_back(e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_pc    = p;
    endtask

    initial begin
        reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
        ld_valid = 1'b0; ld_addr = '0; dm_readData = '0;

        // Reset then idle
        repeat (3) tick();
        at_neg();
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_memwrite", 32'(dm_MemWrite), 32'd0);
        tick();
        reset = 1'b1;

        // Single store, written the cycle after acceptance
        push(32'h10, 32'hDEADBEEF, 32'h3000);
        tick();
        st_valid = 1'b0;
        at_neg();
        chk("single_memwrite", 32'(dm_MemWrite), 32'd1);
        chk("single_addr", dm_addr, 32'h10);
        chk("single_wdata", dm_writeData, 32'hDEADBEEF);
        chk("single_pc", dm_PC, 32'h3000);
        tick();
        at_neg();
        chk("single_empty", 32'(empty), 32'd1);

        // Fill behind a non-matching load, drop the fifth, then drain in order
        ld_valid = 1'b1; ld_addr = 32'h100;
        for (int i = 0; i < 5; i++) begin
            push(32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 32'h4000 + 32'(4 * i));
            if (i == 4) begin
                at_neg();
                chk("fill_st_ready", 32'(st_ready), 32'd0);
                chk("fill_count4", 32'(count), 32'd4);
            end
            tick();
        end
        st_valid = 1'b0;
        at_neg();
        chk("fill_count_after_drop", 32'(count), 32'd4);
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("fill_drain_wdata", dm_writeData, 32'hA0 + 32'(i));
            chk("fill_drain_addr", dm_addr, 32'h200 + 32'(4 * i));
            tick();
        end
        at_neg();
        chk("fill_empty", 32'(empty), 32'd1);

        // Forwarding picks the youngest matching store
        ld_valid = 1'b1; ld_addr = 32'h40;
        push(32'h20, 32'h1111, 32'h5000);
        tick();
        push(32'h20, 32'h2222, 32'h5004);
        tick();
        st_valid = 1'b0;
        ld_addr = 32'h23;
        at_neg();
        chk("fwd_hit", 32'(ld_hit), 32'd1);
        chk("fwd_data", ld_data, 32'h2222);
        chk("fwd_drain_during_hit", dm_writeData, 32'h1111);
        tick();
        ld_valid = 1'b0;
        repeat (2) tick();

        // Load miss owns the port; the pending drain follows afterwards
        ld_valid = 1'b1; ld_addr = 32'h80; dm_readData = 32'hCAFE;
        push(32'h84, 32'h55, 32'h6000);
        tick();
        st_valid = 1'b0;
        at_neg();
        chk("prio_dm_addr", dm_addr, 32'h80);
        chk("prio_memwrite", 32'(dm_MemWrite), 32'd0);
        chk("prio_ld_hit", 32'(ld_hit), 32'd0);
        chk("prio_ld_data", ld_data, 32'hCAFE);
        chk("prio_count", 32'(count), 32'd1);
        tick();
        ld_valid = 1'b0;
        at_neg();
        chk("prio_drain_next", 32'(dm_MemWrite), 32'd1);
        chk("prio_drain_addr", dm_addr, 32'h84);
        tick();

        // Push together with drain at count 2 keeps the count and the order
        ld_valid = 1'b1; ld_addr = 32'h100;
        push(32'h300, 32'hB1, 32'h7000);
        tick();
        push(32'h304, 32'hB2, 32'h7004);
        tick();
        ld_valid = 1'b0;
        push(32'h308, 32'hB3, 32'h7008);
        at_neg();
        chk("pd_count_before", 32'(count), 32'd2);
        chk("pd_wdata1", dm_writeData, 32'hB1);
        tick();
        st_valid = 1'b0;
        at_neg();
        chk("pd_count_after", 32'(count), 32'd2);
        chk("pd_wdata2", dm_writeData, 32'hB2);
        tick();
        at_neg();
        chk("pd_wdata3", dm_writeData, 32'hB3);
        tick();

        // Reset mid-drain discards pending stores with no later write
        ld_valid = 1'b1; ld_addr = 32'h100;
        push(32'h400, 32'hC1, 32'h8000);
        tick();
        push(32'h404, 32'hC2, 32'h8004);
        tick();
        st_valid = 1'b0; ld_valid = 1'b0;
        at_neg();
        chk("rmid_count_before", 32'(count), 32'd2);
        reset = 1'b0;
        #1;
        chk("rmid_count_now", 32'(count), 32'd0);
        chk("rmid_memwrite_now", 32'(dm_MemWrite), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        at_neg();
        chk("rmid_no_write", 32'(dm_MemWrite), 32'd0);
        chk("rmid_empty", 32'(empty), 32'd1);
        tick();

        // Randomized traffic; the compare process checks every cycle
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            st_valid    = (r < 40) || (r >= 96);
            ld_valid    = (r >= 40 && r < 75) || (r >= 96);
            st_addr     = 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
            ld_addr     = 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
            st_data     = $urandom;
            st_pc       = $urandom;
            dm_readData = $urandom;
            reset       = ($urandom_range(0, 199) != 0);
            tick();
        end
        reset = 1'b1; st_valid = 1'b0; ld_valid = 1'b0;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
